// File: rtl/sha256_main.sv
`timescale 1ns/1ps
// sha256_main: single-block SHA-256 hasher for an N-bit message.
// Pads internally, runs 4 compression rounds per clock and restarts
// itself whenever the message or length field changes.
//
// state | meaning
// IDLE  | digest (if any) held; watching inputs for a change
// ROUND | 16 cycles of 4 rounds each, schedule as a 16-word window
// FINAL | add IV to working vars, publish digest, raise done
module sha256_main #(
    parameter int N = 88
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] data,
    input  logic [63:0]  m2b,
    output logic [255:0] final_op,
    output logic         done
);

    typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, FINAL = 2'd2} state_t;

    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t            state_q;
    logic              fresh_q;
    logic [N-1:0]      data_q;
    logic [63:0]       m2b_q;
    logic [3:0]        cyc_q;
    logic [0:7][31:0]  hv_q, hv_d;
    logic [0:15][31:0] w_q, w_d, w_init;
    logic [0:7][31:0]  digest_d;
    logic              chg;

    // A fresh reset or any difference from the latched operands starts a new hash
    assign chg = fresh_q || (data != data_q) || (m2b != m2b_q);

    // Padded block built from the live inputs; word 0 sits in bits [511:480]
    always_comb begin
        logic [511:0] blk;
        blk           = '0;
        blk[511 -: N] = data;
        blk[511 - N]  = 1'b1;
        blk[63:0]     = m2b;
        w_init        = blk;
    end

    // Four rounds per cycle; the schedule window slides forward by four words
    always_comb begin
        logic [0:19][31:0] ext;
        logic [0:7][31:0]  v;
        logic [31:0]       t1, t2;
        ext = '0;
        for (int j = 0; j < 16; j++) ext[j] = w_q[j];
        for (int j = 16; j < 20; j++)
            ext[j] = ssig1(ext[j-2]) + ext[j-7] + ssig0(ext[j-15]) + ext[j-16];
        for (int j = 0; j < 16; j++) w_d[j] = ext[j+4];
        v = hv_q;
        for (int r = 0; r < 4; r++) begin
            t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
                 + K[{cyc_q, 2'(r)}] + ext[r];
            t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v  = {t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6]};
        end
        hv_d = v;
        for (int i = 0; i < 8; i++) digest_d[i] = IV[i] + hv_q[i];
    end

    // Control FSM with registered digest/done; an input change restarts from round 0 in any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            fresh_q  <= 1'b1;
            data_q   <= '0;
            m2b_q    <= '0;
            cyc_q    <= '0;
            hv_q     <= '0;
            w_q      <= '0;
            final_op <= '0;
            done     <= 1'b0;
        end else if (chg) begin
            data_q  <= data;
            m2b_q   <= m2b;
            w_q     <= w_init;
            hv_q    <= IV;
            cyc_q   <= '0;
            fresh_q <= 1'b0;
            done    <= 1'b0;
            state_q <= ROUND;
        end else begin
            case (state_q)
                IDLE: state_q <= IDLE;
                ROUND: begin
                    hv_q  <= hv_d;
                    w_q   <= w_d;
                    cyc_q <= cyc_q + 4'd1;
                    if (cyc_q == 4'd15) state_q <= FINAL;
                end
                FINAL: begin
                    final_op <= digest_d;
                    done     <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_main.sv
`timescale 1ns/1ps
// Bench for sha256_main: three instances (N=88, 24, 447) against a plain
// 64-word software SHA-256 model plus published digests.
module tb_sha256_main;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [87:0]  d88;  logic [63:0] l88;  logic [255:0] f88;  logic dn88;
    logic [23:0]  d24;  logic [63:0] l24;  logic [255:0] f24;  logic dn24;
    logic [446:0] d447; logic [63:0] l447; logic [255:0] f447; logic dn447;

    sha256_main #(.N(88))  u88  (.clk(clk), .rst(rst), .data(d88),  .m2b(l88),  .final_op(f88),  .done(dn88));
    sha256_main #(.N(24))  u24  (.clk(clk), .rst(rst), .data(d24),  .m2b(l24),  .final_op(f24),  .done(dn24));
    sha256_main #(.N(447)) u447 (.clk(clk), .rst(rst), .data(d447), .m2b(l447), .final_op(f447), .done(dn447));

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [87:0]  HW     = 88'h48656C6C6F20576F726C64;  // "Hello World"
    localparam logic [87:0]  HWE    = 88'h48656C6C6F20576F726C65;  // "Hello Worle"
    localparam logic [87:0]  HW_LC  = 88'h68656C6C6F20776F726C64;  // "hello world"
    localparam logic [23:0]  ABC    = 24'h616263;
    localparam logic [255:0] KAT_HW    = 256'ha591a6d40bf420404a011733cfb7b190d62c65bf0bcda32b57b277d9ad9f146e;
    localparam logic [255:0] KAT_HW_LC = 256'hb94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9;
    localparam logic [255:0] KAT_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [31:0] IVT [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Straight software SHA-256 of one 512-bit block: full 64-word expansion, one round per step
    function automatic logic [255:0] sha_ref(input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        logic [255:0] res;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = blk[511 - 32*t -: 32];
            else begin
                s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
        end
        a = IVT[0]; b = IVT[1]; c = IVT[2]; d = IVT[3];
        e = IVT[4]; f = IVT[5]; g = IVT[6]; h = IVT[7];
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        res = {IVT[0] + a, IVT[1] + b, IVT[2] + c, IVT[3] + d,
               IVT[4] + e, IVT[5] + f, IVT[6] + g, IVT[7] + h};
        return res;
    endfunction

    // Message left-justified with zeros below; append the 1 bit and the length field
    function automatic logic [511:0] pad(input logic [511:0] msg, input int n, input logic [63:0] len);
        logic [511:0] blk;
        blk = msg;
        blk[511 - n] = 1'b1;
        blk[63:0] = len;
        return blk;
    endfunction

    function automatic logic [255:0] ref88(input logic [87:0] d, input logic [63:0] l);
        return sha_ref(pad({d, 424'b0}, 88, l));
    endfunction
    function automatic logic [255:0] ref24(input logic [23:0] d, input logic [63:0] l);
        return sha_ref(pad({d, 488'b0}, 24, l));
    endfunction
    function automatic logic [255:0] ref447(input logic [446:0] d, input logic [63:0] l);
        return sha_ref(pad({d, 65'b0}, 447, l));
    endfunction

    function automatic logic [87:0] rnd88();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        return r[87:0];
    endfunction

    task automatic chk256(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Edges from the input drive until done is seen (1 = sampling edge); -1 if never
    task automatic wait88(output int lat);
        lat = -1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (dn88) lat = c;
        end
    endtask
    task automatic wait24(output int lat);
        lat = -1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (dn24) lat = c;
        end
    endtask
    task automatic wait447(output int lat);
        lat = -1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (dn447) lat = c;
        end
    endtask

    typedef struct {
        logic [87:0]  d;
        logic [63:0]  l;
        logic [255:0] exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, lat88, lat24, lat447;
        logic [255:0] prev, exp_y;
        logic [87:0]  y;
        logic [447:0] r448;

        for (int i = 0; i < 8; i++) begin
            vecs[i].d = rnd88();
            vecs[i].l = 64'd88;
        end
        vecs[0].d = HWE;
        vecs[1].d = HW_LC;
        vecs[6].l = {$urandom, $urandom};
        vecs[7].d = HW;
        for (int i = 0; i < 8; i++) vecs[i].exp = ref88(vecs[i].d, vecs[i].l);
        vecs[1].exp = KAT_HW_LC;
        vecs[7].exp = KAT_HW;

        rst  = 1'b1;
        d88  = HW;  l88  = 64'd88;
        d24  = ABC; l24  = 64'd24;
        d447 = '1;  l447 = 64'd447;
        repeat (2) @(negedge clk);
        chk256("rst_final88",  f88,  '0);  chk_int("rst_done88",  int'(dn88),  0);
        chk256("rst_final24",  f24,  '0);  chk_int("rst_done24",  int'(dn24),  0);
        chk256("rst_final447", f447, '0);  chk_int("rst_done447", int'(dn447), 0);

        rst = 1'b0;
        lat88 = -1; lat24 = -1; lat447 = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (dn88  && lat88  < 0) lat88  = c;
            if (dn24  && lat24  < 0) lat24  = c;
            if (dn447 && lat447 < 0) lat447 = c;
        end
        chk_int("post_rst_lat88", lat88, 18);
        chk_int("post_rst_lat24", lat24, 18);
        chk_int("post_rst_lat447", lat447, 18);
        chk256("hello_world_digest", f88, KAT_HW);
        chk256("abc_digest_after_rst", f24, KAT_ABC);
        chk256("ones447_digest", f447, ref447({447{1'b1}}, 64'd447));

        @(negedge clk); d24 = 24'($urandom);
        wait24(lat);
        chk256("rand24_digest", f24, ref24(d24, 64'd24));
        @(negedge clk); d24 = ABC;
        wait24(lat);
        chk_int("abc_latency_edges", lat, 18);
        chk256("abc_digest", f24, KAT_ABC);

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            d88 = vecs[i].d; l88 = vecs[i].l;
            wait88(lat);
            chk_int($sformatf("vec%0d_latency", i), lat, 18);
            chk256($sformatf("vec%0d_digest", i), f88, vecs[i].exp);
        end

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 14; i++) r448[i*32 +: 32] = $urandom;
            @(negedge clk);
            d447 = r448[446:0]; l447 = 64'd447;
            wait447(lat);
            chk_int("rand447_latency", lat, 18);
            chk256("rand447_digest", f447, ref447(d447, 64'd447));
        end

        @(negedge clk); d88 = rnd88(); l88 = 64'd88;
        wait88(lat);
        prev = ref88(d88, 64'd88);
        chk256("pre_abort_digest", f88, prev);
        @(negedge clk); d88 = HW;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk_int("abort_done_low", int'(dn88), 0);
            chk256("abort_hold_prev", f88, prev);
        end
        @(negedge clk); d88 = HWE;
        lat = -1;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(posedge clk); #1;
            if (dn88) lat = c;
            else chk256("abort_no_stale", f88, prev);
        end
        chk_int("abort_restart_latency", lat, 18);
        chk256("abort_final_digest", f88, ref88(HWE, 64'd88));

        y = rnd88();
        exp_y = ref88(y, 64'd88);
        @(negedge clk); d88 = y;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk256("async_rst_final", f88, '0);
        chk_int("async_rst_done", int'(dn88), 0);
        @(negedge clk); rst = 1'b0;
        wait88(lat);
        chk_int("post_midrst_latency", lat, 18);
        chk256("post_midrst_digest", f88, exp_y);

        for (int c = 0; c < 100; c++) begin
            @(posedge clk); #1;
            chk256("stable_final", f88, exp_y);
            chk_int("stable_done", int'(dn88), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
